// File: rtl/fp_mul_ctrl_pkg.sv
// Shared types and constants for the fp_mul_ctrl sequencer.
//   state_e     : controller FSM states
//   rmode_e     : IEEE-754 rounding modes accepted by the multiplier
//   op_t        : operand bundle latched from the winning requester
//   rsp_t       : captured result bundle returned to the consumer
//   rmode_legal : true for rounding modes the datapath implements
package fp_mul_ctrl_pkg;

    localparam int unsigned FP_W = 32;
    localparam int unsigned RM_W = 3;
    localparam int unsigned OPS_W = 16;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [RM_W-1:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rmode_e;

    typedef struct packed {
        logic [FP_W-1:0] x;
        logic [FP_W-1:0] y;
        logic [RM_W-1:0] rmode;
    } op_t;

    typedef struct packed {
        logic [FP_W-1:0] z;
        logic            ovrf;
        logic            udrf;
        logic            err;
    } rsp_t;

    // Encodings above RMM are reserved and must bypass the multiplier.
    function automatic logic rmode_legal(input logic [RM_W-1:0] rm);
        return (rm <= RM_W'(RMM));
    endfunction

endpackage

// File: rtl/fp_mul_ctrl_rr_arbiter.sv
// Round-robin arbiter: scans requests starting one past the last grant.
//   req_i        : request vector, one bit per requester
//   last_grant_i : index granted most recently
//   en_i         : arbitration enable; no grant when low
//   gnt_o        : one-hot grant (or zero)
//   gnt_idx_o    : encoded index of the granted requester
//   gnt_any_o    : a grant was issued
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_any_o
);

    logic [IDW-1:0] cand;
    logic           found;

    // Offsets 1..NREQ wrap around so the previous winner is checked last.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(last_grant_i) + i) % NREQ);
            if (en_i && !found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                gnt_idx_o    = cand;
            end
        end
        gnt_any_o = found;
    end

endmodule

// File: rtl/fp_mul_ctrl.sv
// Shares one combinational fp multiplier between NREQ requesters.
// A round-robin winner's operands are registered onto mul_*, held for
// MUL_LAT cycles, then the result and flags are captured and returned on a
// valid/ready response channel tagged with the requester id.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/ready          : per-requester handshake (ready is one-hot)
//   req_x/req_y/req_rmode    : packed per-requester operands
//   mul_x/mul_y/mul_rmode    : registered operands to the datapath
//   mul_z/mul_ovrf/mul_udrf  : datapath result and flags
//   rsp_*                    : registered response channel
//   busy                     : controller not idle
//   ops_done                 : wrapping count of completed responses
module fp_mul_ctrl
    import fp_mul_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [FP_W*NREQ-1:0] req_x,
    input  logic [FP_W*NREQ-1:0] req_y,
    input  logic [RM_W*NREQ-1:0] req_rmode,
    output logic [FP_W-1:0]      mul_x,
    output logic [FP_W-1:0]      mul_y,
    output logic [RM_W-1:0]      mul_rmode,
    input  logic [FP_W-1:0]      mul_z,
    input  logic                 mul_ovrf,
    input  logic                 mul_udrf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [FP_W-1:0]      rsp_z,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_ovrf,
    output logic                 rsp_udrf,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [OPS_W-1:0]     ops_done
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    state_e            state_q,      state_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    op_t               op_q,         op_d;
    rsp_t              rsp_q,        rsp_d;
    logic [IDW-1:0]    rsp_id_q,     rsp_id_d;
    logic [OPS_W-1:0]  ops_done_q,   ops_done_d;

    op_t               req_op [NREQ];
    op_t               sel_op;
    logic              arb_en;
    logic [NREQ-1:0]   arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic              arb_any;

    // Unpack the flat requester buses into per-requester operand bundles.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_op[i].x     = req_x[i*FP_W +: FP_W];
            req_op[i].y     = req_y[i*FP_W +: FP_W];
            req_op[i].rmode = req_rmode[i*RM_W +: RM_W];
        end
    end

    // Gating with rst keeps req_ready low while reset is held.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .en_i         (arb_en),
        .gnt_o        (arb_gnt),
        .gnt_idx_o    (arb_idx),
        .gnt_any_o    (arb_any)
    );

    assign sel_op    = req_op[arb_idx];
    assign req_ready = arb_gnt;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            cnt_q        <= '0;
            op_q         <= '0;
            rsp_q        <= '0;
            rsp_id_q     <= '0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            rsp_q        <= rsp_d;
            rsp_id_q     <= rsp_id_d;
            ops_done_q   <= ops_done_d;
        end
    end

    // Next-state logic: accept, wait out the multiplier latency, respond.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        rsp_d        = rsp_q;
        rsp_id_d     = rsp_id_q;
        ops_done_d   = ops_done_q;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    last_grant_d = arb_idx;
                    rsp_id_d     = arb_idx;
                    if (rmode_legal(sel_op.rmode)) begin
                        op_d    = sel_op;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        state_d = BUSY;
                    end else begin
                        // Reserved rounding mode: answer with a quiet NaN and
                        // leave the multiplier operands untouched.
                        rsp_d.z    = FP_QNAN;
                        rsp_d.ovrf = 1'b0;
                        rsp_d.udrf = 1'b0;
                        rsp_d.err  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rsp_d.z    = mul_z;
                    rsp_d.ovrf = mul_ovrf;
                    rsp_d.udrf = mul_udrf;
                    rsp_d.err  = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + OPS_W'(1);
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mul_x     = op_q.x;
    assign mul_y     = op_q.y;
    assign mul_rmode = op_q.rmode;

    assign rsp_valid = (state_q == RESP);
    assign rsp_z     = rsp_q.z;
    assign rsp_ovrf  = rsp_q.ovrf;
    assign rsp_udrf  = rsp_q.udrf;
    assign rsp_err   = rsp_q.err;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_done_q;

endmodule

// File: doc/fp_mul_ctrl.md
Name: fp_mul_ctrl

Overview:
- Sequencer/arbiter that shares one combinational fp_mul datapath (fp_X, fp_Y, r_mode -> fp_Z, ovrf, udrf) between NREQ requesters.
- Arbitrates round-robin and registers the winning operands.
- Holds them stable for MUL_LAT cycles, captures the result and flags, and returns them over a valid/ready response channel tagged with the requester id.
- One operation in flight at a time.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MUL_LAT, 1, cycles from operand-register update to result sampling (>=1).
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  request accepted, one-hot or zero
- req_x  in  32*NREQ  operand X per requester, IEEE-754 single
- req_y  in  32*NREQ  operand Y per requester
- req_rmode  in  3*NREQ  rounding mode per requester
- mul_x  out  32  to datapath fp_X
- mul_y  out  32  to datapath fp_Y
- mul_rmode  out  3  to datapath r_mode
- mul_z  in  32  from datapath fp_Z
- mul_ovrf  in  1  from datapath overflow
- mul_udrf  in  1  from datapath underflow
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_z  out  32  result
- rsp_id  out  IDW  requester index of this result
- rsp_ovrf  out  1  captured overflow
- rsp_udrf  out  1  captured underflow
- rsp_err  out  1  illegal rounding mode, multiplier bypassed
- busy  out  1  state != IDLE
- ops_done  out  16  completed responses, wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=NREQ-1 (requester 0 wins first).
  - Counter=0, all operand/result registers and outputs 0, rsp_valid=0, req_ready=0, ops_done=0.
- Reset mid-operation abandons the transaction; no response is produced.
- IDLE:
  - Grant g = first requester with req_valid set, scanning from last_grant+1 modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On handshake: latch x, y, rmode and id=g; set last_grant=g.
  - Legal rmode (000..100): set cnt=MUL_LAT-1 and go to BUSY.
  - Illegal rmode (101..111): set rsp_z=0x7FC00000, rsp_err=1, ovrf=udrf=0; go straight to RESP. The mul_* registers are not updated.
- BUSY:
  - mul_x/mul_y/mul_rmode driven from operand registers and stable.
  - If cnt==0: capture mul_z, mul_ovrf, mul_udrf into rsp regs, set rsp_err=0, go to RESP.
  - Otherwise decrement cnt.
  - With MUL_LAT=1, capture happens in the cycle after acceptance.
  - req_ready=0 throughout.
- RESP:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0 (indefinite backpressure allowed).
  - On rsp_valid&&rsp_ready: go to IDLE, ops_done+=1.
  - req_ready=0 in RESP; a new grant is possible no earlier than the following IDLE cycle.
  - Throughput is at most one operation per MUL_LAT+2 cycles.
- mul_* outputs keep their last value outside BUSY (no toggling when idle).
- req_valid dropping before handshake is legal; the arbiter re-evaluates every IDLE cycle.
- cnt width is $clog2(MUL_LAT+1).
- No combinational path from mul_z to rsp_z.

Decomposition:
- Package fp_mul_ctrl_pkg:
  - state enum {IDLE, BUSY, RESP}.
  - rmode enum {RNE=3'b000, RTZ=3'b001, RDN=3'b010, RUP=3'b011, RMM=3'b100}.
  - FP_QNAN=32'h7FC00000.
  - rmode_legal() function.
- Sub-module rr_arbiter: NREQ-wide round-robin, inputs req vector, last_grant and enable; outputs one-hot grant and encoded index.

Test Plan:
- Req0 x=0x40400000, y=0x40400000, rmode=001, MUL_LAT=1 -> req_ready[0] in the same cycle; mul_x=0x40400000 in BUSY; rsp_valid 2 cycles after acceptance with rsp_z=0x41100000, rsp_id=0, flags 0, ops_done=1.
- Req0 and req1 both valid from reset -> grant order 0, 1, 0 when both stay valid; rsp_id follows the same order; never two req_ready bits high.
- Req1 rmode=3'b101 -> rsp_z=0x7FC00000, rsp_err=1, rsp_valid the cycle after acceptance; mul_x/mul_y unchanged from the previous value.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_z/rsp_id/flags stable; req_ready stays 0 despite req_valid; completes on the cycle rsp_ready=1.
- x=y=0x7F000000, rmode=000, datapath returns ovrf=1 -> rsp_ovrf=1, rsp_z equals mul_z captured at cnt==0.
- rst pulsed during BUSY (MUL_LAT=3) -> all outputs 0 immediately; no rsp_valid afterwards; next grant goes to requester 0; ops_done=0.
